// File: rtl/dmem_bank_ctrl_if.sv
// LSU request/response handshake plus the four byte-bank lanes of the data memory.
// The master side is the LSU together with the banks; the slave side is the bank controller.
interface dmem_bank_ctrl_if #(
  parameter int ROW_W = 14
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [1:0]           req_size_i;
  logic                 req_unsigned_i;
  logic [ROW_W+1:0]     req_addr_i;
  logic [31:0]          req_wdata_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [31:0]          rsp_rdata_o;
  logic                 rsp_err_o;
  logic [4*ROW_W-1:0]   bank_addr_o;
  logic [3:0]           bank_wren_o;
  logic [31:0]          bank_wdata_o;
  logic [31:0]          bank_rdata_i;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output rsp_ready_i, bank_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  bank_addr_o, bank_wren_o, bank_wdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i, bank_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output bank_addr_o, bank_wren_o, bank_wdata_o
  );
endinterface

// File: rtl/dmem_bank_ctrl.sv
// Byte-bank data memory requester: one load/store per IDLE->ACCESS->RESP pass, misaligned handled in one cycle.
// Banks touched one cycle after accept; response held until consumed; no new request accepted meanwhile.
module dmem_bank_ctrl #(
  parameter int ROW_W            = 14,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmem_bank_ctrl_if.slave bus
);
  localparam int AW = ROW_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_addr;
  logic [1:0]      r_size;
  logic            r_we;
  logic            r_uns;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic [2:0]         w_nbytes;
  logic               w_mis;
  logic               w_err;
  logic [AW-1:0]      w_ba [4];
  logic [4*ROW_W-1:0] w_bank_addr;
  logic [3:0]         w_lane_en;
  logic [31:0]        w_bank_wdata;
  logic [31:0]        w_raw;
  logic [31:0]        w_ext;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req_valid_i) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (bus.rsp_ready_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.req_valid_i) begin
        r_addr  <= bus.req_addr_i;
        r_size  <= bus.req_size_i;
        r_we    <= bus.req_we_i;
        r_uns   <= bus.req_unsigned_i;
        r_wdata <= bus.req_wdata_i;
      end
      if (r_state == S_ACCESS) begin
        r_rdata <= w_ext;
        r_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_nbytes = 3'd0;
    w_mis    = 1'b0;
    case (r_size)
      2'b00: w_nbytes = 3'd1;
      2'b01: begin w_nbytes = 3'd2; w_mis = r_addr[0];    end
      2'b10: begin w_nbytes = 3'd4; w_mis = |r_addr[1:0]; end
      default: w_nbytes = 3'd0;
    endcase
  end

  assign w_err = (r_size == 2'b11) || (!ALLOW_MISALIGNED && w_mis);

  // Byte i lands in bank (A+i)[1:0]; the natural AW-bit wrap takes top-of-memory to row 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_ba[i] = r_addr + AW'(i);
    end
  end

  always_comb begin
    w_bank_addr  = {4{r_addr[AW-1:2]}};
    w_lane_en    = '0;
    w_bank_wdata = '0;
    w_raw        = '0;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = int'(w_ba[i][1:0]);
      if (3'(i) < w_nbytes) begin
        w_bank_addr[k*ROW_W +: ROW_W] = w_ba[i][AW-1:2];
        w_lane_en[k]                  = 1'b1;
        w_bank_wdata[k*8 +: 8]        = r_wdata[i*8 +: 8];
        w_raw[i*8 +: 8]               = bus.bank_rdata_i[k*8 +: 8];
      end
    end
  end

  always_comb begin
    w_ext = w_raw;
    case (w_nbytes)
      3'd1: w_ext = r_uns ? {24'h0, w_raw[7:0]}  : {{24{w_raw[7]}}, w_raw[7:0]};
      3'd2: w_ext = r_uns ? {16'h0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
    if (r_we || w_err) w_ext = '0;
  end

  // Write enables depend only on registered state so IDLE-time input activity cannot reach the banks.
  assign bus.bank_wren_o  = (r_state == S_ACCESS && r_we && !w_err) ? w_lane_en : 4'b0000;
  assign bus.bank_wdata_o = (r_we && !w_err) ? w_bank_wdata : 32'h0;
  assign bus.bank_addr_o  = w_bank_addr;
  assign bus.req_ready_o  = (r_state == S_IDLE);
  assign bus.rsp_valid_o  = (r_state == S_RESP);
  assign bus.rsp_rdata_o  = r_rdata;
  assign bus.rsp_err_o    = r_err;
endmodule

// File: tb/tb_dmem_bank_ctrl.sv
// Directed bench: two controllers (misaligned allowed / rejected) share one stimulus stream, each with its own bank model.
module tb_dmem_bank_ctrl;
  localparam int RW = 14;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic        req_valid, req_we, req_uns, rsp_ready;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;

  dmem_bank_ctrl_if #(.ROW_W(RW)) if0 ();
  dmem_bank_ctrl_if #(.ROW_W(RW)) if1 ();

  assign if0.req_valid_i = req_valid;  assign if1.req_valid_i = req_valid;
  assign if0.req_we_i = req_we;        assign if1.req_we_i = req_we;
  assign if0.req_size_i = req_size;    assign if1.req_size_i = req_size;
  assign if0.req_unsigned_i = req_uns; assign if1.req_unsigned_i = req_uns;
  assign if0.req_addr_i = req_addr;    assign if1.req_addr_i = req_addr;
  assign if0.req_wdata_i = req_wdata;  assign if1.req_wdata_i = req_wdata;
  assign if0.rsp_ready_i = rsp_ready;  assign if1.rsp_ready_i = rsp_ready;

  dmem_bank_ctrl #(.ROW_W(RW), .ALLOW_MISALIGNED(1'b1)) u_dut0 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if0));
  dmem_bank_ctrl #(.ROW_W(RW), .ALLOW_MISALIGNED(1'b0)) u_dut1 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if1));

  logic [7:0] m0 [4][1<<RW];
  logic [7:0] m1 [4][1<<RW];

  for (genvar k = 0; k < 4; k++) begin : g_bank
    assign if0.bank_rdata_i[8*k +: 8] = m0[k][if0.bank_addr_o[k*RW +: RW]];
    assign if1.bank_rdata_i[8*k +: 8] = m1[k][if1.bank_addr_o[k*RW +: RW]];
  end

  always @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (if0.bank_wren_o[k]) m0[k][if0.bank_addr_o[k*RW +: RW]] <= if0.bank_wdata_o[8*k +: 8];
      if (if1.bank_wren_o[k]) m1[k][if1.bank_addr_o[k*RW +: RW]] <= if1.bank_wdata_o[8*k +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  wren0, wren1;
  logic [31:0] rd0, rd1, old0, old1;
  logic        er0, er1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction; hold = cycles the response is left unconsumed after it first appears.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [15:0] a, input logic [31:0] wd, input int hold);
    int n;
    @(negedge clk_i);
    req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b0;
    chk("rdy_idle", {31'b0, if0.req_ready_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid = 1'b0;
    wren0 = if0.bank_wren_o;
    wren1 = if1.bank_wren_o;
    chk("rdy_busy", {31'b0, if0.req_ready_o}, 32'd0);
    n = 0;
    while (!if0.rsp_valid_o && n < 8) begin
      @(negedge clk_i);
      n++;
    end
    chk("rsp_lat", n, 32'd1);
    rd0 = if0.rsp_rdata_o; er0 = if0.rsp_err_o;
    rd1 = if1.rsp_rdata_o; er1 = if1.rsp_err_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk("hold_vld", {31'b0, if0.rsp_valid_o}, 32'd1);
      chk("hold_dat", if0.rsp_rdata_o, rd0);
      chk("hold_rdy", {31'b0, if0.req_ready_o}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'b0, if0.rsp_valid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_uns = 1'b0; rsp_ready = 1'b0;
    req_size = 2'b00; req_addr = '0; req_wdata = '0;
    #1;
    chk("rst_wren", {28'b0, if0.bank_wren_o}, 32'd0);
    chk("rst_vld",  {31'b0, if0.rsp_valid_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_rdy",   {31'b0, if0.req_ready_o}, 32'd1);
    chk("rst_rdata", if0.rsp_rdata_o, 32'd0);
    chk("rst_err",   {31'b0, if0.rsp_err_o}, 32'd0);

    // Aligned word store then load, response held for 5 cycles
    txn(1'b1, 2'b10, 1'b0, 16'h0010, 32'hA1B2C3D4, 0);
    chk("sw_wren", {28'b0, wren0}, 32'h0000000F);
    chk("sw_mem",  {m0[3][4], m0[2][4], m0[1][4], m0[0][4]}, 32'hA1B2C3D4);
    chk("sw_ack",  rd0, 32'h0);
    txn(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 5);
    chk("lw_data", rd0, 32'hA1B2C3D4);
    chk("lw_err",  {31'b0, er0}, 32'd0);

    // Byte store into the top lane, signed and unsigned reloads
    txn(1'b1, 2'b00, 1'b0, 16'h0013, 32'h00000080, 0);
    chk("sb_wren", {28'b0, wren0}, 32'h00000008);
    chk("sb_mem",  {m0[3][4], m0[2][4], m0[1][4], m0[0][4]}, 32'h80B2C3D4);
    txn(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 0);
    chk("lb_s", rd0, 32'hFFFFFF80);
    txn(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 0);
    chk("lbu",  rd0, 32'h00000080);

    // Word crossing into the next row
    old1 = {m1[1][2], m1[0][2], m1[3][1], m1[2][1]};
    txn(1'b1, 2'b10, 1'b0, 16'h0006, 32'h11223344, 0);
    chk("msw_wren", {28'b0, wren0}, 32'h0000000F);
    chk("msw_mem",  {m0[1][2], m0[0][2], m0[3][1], m0[2][1]}, 32'h11223344);
    chk("msw_err1", {31'b0, er1}, 32'd1);
    chk("msw_wren1", {28'b0, wren1}, 32'd0);
    chk("msw_mem1", {m1[1][2], m1[0][2], m1[3][1], m1[2][1]}, old1);
    txn(1'b0, 2'b10, 1'b0, 16'h0006, 32'h0, 0);
    chk("mlw_data", rd0, 32'h11223344);
    chk("mlw_rd1",  rd1, 32'h0);

    // Half at the very top of memory wraps to row 0
    old1 = {16'h0, m1[0][0], m1[3][16383]};
    txn(1'b1, 2'b01, 1'b0, 16'hFFFF, 32'h0000BEEF, 0);
    chk("wsh_wren", {28'b0, wren0}, 32'h00000009);
    chk("wsh_mem",  {16'h0, m0[0][0], m0[3][16383]}, 32'h0000BEEF);
    chk("wsh_err1", {31'b0, er1}, 32'd1);
    chk("wsh_mem1", {16'h0, m1[0][0], m1[3][16383]}, old1);
    txn(1'b0, 2'b01, 1'b1, 16'hFFFF, 32'h0, 0);
    chk("wlhu", rd0, 32'h0000BEEF);
    txn(1'b0, 2'b01, 1'b0, 16'hFFFF, 32'h0, 0);
    chk("wlh_s", rd0, 32'hFFFFBEEF);

    // Reserved size
    txn(1'b1, 2'b11, 1'b0, 16'h0010, 32'hFFFFFFFF, 0);
    chk("rsv_err",  {31'b0, er0}, 32'd1);
    chk("rsv_wren", {28'b0, wren0}, 32'd0);
    txn(1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, 0);
    chk("rsv_rdata", rd0, 32'h0);
    chk("rsv_err2",  {31'b0, er0}, 32'd1);

    // Reset landing in the ACCESS cycle of a store
    old0 = {m0[3][8], m0[2][8], m0[1][8], m0[0][8]};
    @(negedge clk_i);
    req_we = 1'b1; req_size = 2'b10; req_uns = 1'b0; req_addr = 16'h0020; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ra_wren_on", {28'b0, if0.bank_wren_o}, 32'h0000000F);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("ra_wren_off", {28'b0, if0.bank_wren_o}, 32'd0);
    chk("ra_vld",      {31'b0, if0.rsp_valid_o}, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("ra_mem", {m0[3][8], m0[2][8], m0[1][8], m0[0][8]}, old0);
    rst_ni = 1'b1;
    txn(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, 0);
    chk("ra_reload", rd0, old0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
